// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
// Package     : meas_pkg
// Description : Shared frame layout and FSM encoding for the measurement
//               result frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package meas_pkg;

  localparam int         FRAME_LEN  = 13;
  localparam logic [7:0] HEADER_DEF = 8'hA5;

  // Byte positions inside the frame (MSB-first fields).
  localparam logic [3:0] IDX_HDR   = 4'd0;
  localparam logic [3:0] IDX_FREQ3 = 4'd1;
  localparam logic [3:0] IDX_FREQ2 = 4'd2;
  localparam logic [3:0] IDX_FREQ1 = 4'd3;
  localparam logic [3:0] IDX_FREQ0 = 4'd4;
  localparam logic [3:0] IDX_DUTY  = 4'd5;
  localparam logic [3:0] IDX_HIGH2 = 4'd6;
  localparam logic [3:0] IDX_HIGH1 = 4'd7;
  localparam logic [3:0] IDX_HIGH0 = 4'd8;
  localparam logic [3:0] IDX_LOW2  = 4'd9;
  localparam logic [3:0] IDX_LOW1  = 4'd10;
  localparam logic [3:0] IDX_LOW0  = 4'd11;
  localparam logic [3:0] IDX_CSUM  = 4'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage : meas_pkg
`default_nettype wire

// File: rtl/meas_frame_byte_sel.sv
`default_nettype none
// ============================================================================
// Module      : meas_frame_byte_sel
// Description : Combinational frame byte multiplexer. Selects the byte at
//               byte_idx from header, active result fields and checksum.
// Ports       : byte_idx  - current frame byte position
//               freq/duty/high/low - active (zero-extended) result fields
//               csum      - running checksum, driven at the last position
//               byte_out  - selected frame byte
// Revision    : 1.0 - initial release
// ============================================================================
module meas_frame_byte_sel
  import meas_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF
) (
  input  logic [3:0]  byte_idx,
  input  logic [31:0] freq,
  input  logic [7:0]  duty,
  input  logic [23:0] high,
  input  logic [23:0] low,
  input  logic [7:0]  csum,
  output logic [7:0]  byte_out
);

  always_comb begin
    byte_out = 8'h00;
    case (byte_idx)
      IDX_HDR:   byte_out = HEADER;
      IDX_FREQ3: byte_out = freq[31:24];
      IDX_FREQ2: byte_out = freq[23:16];
      IDX_FREQ1: byte_out = freq[15:8];
      IDX_FREQ0: byte_out = freq[7:0];
      IDX_DUTY:  byte_out = duty;
      IDX_HIGH2: byte_out = high[23:16];
      IDX_HIGH1: byte_out = high[15:8];
      IDX_HIGH0: byte_out = high[7:0];
      IDX_LOW2:  byte_out = low[23:16];
      IDX_LOW1:  byte_out = low[15:8];
      IDX_LOW0:  byte_out = low[7:0];
      IDX_CSUM:  byte_out = csum;
      default:   byte_out = 8'h00;
    endcase
  end

endmodule : meas_frame_byte_sel
`default_nettype wire

// File: rtl/meas_result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : meas_result_frame_tx
// Description : Captures a measurement result on meas_finish and streams it
//               as a 13-byte frame (header, freq, duty, high, low, checksum)
//               on a valid/ready byte interface. One-deep pending slot holds
//               a result arriving mid-frame; overwrites are counted.
// Ports       : clk, rst_n            - clock, async active-low reset
//               meas_finish + meas_*  - result strobe and fields
//               tx_data/tx_valid/tx_ready - byte stream to the UART
//               tx_busy               - frame in progress
//               frame_done            - pulse after last byte accepted
//               drop_cnt              - saturating overwrite counter
// Revision    : 1.0 - initial release
// ============================================================================
module meas_result_frame_tx
  import meas_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEF,
  parameter int         FREQ_W = 26,
  parameter int         TIME_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_finish,
  input  logic [FREQ_W-1:0] meas_freq,
  input  logic [7:0]        meas_duty,
  input  logic [TIME_W-1:0] meas_high,
  input  logic [TIME_W-1:0] meas_low,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_busy,
  output logic              frame_done,
  output logic [7:0]        drop_cnt
);

  state_t      state, state_nxt;

  logic [31:0] act_freq, pend_freq;
  logic [7:0]  act_duty, pend_duty;
  logic [23:0] act_high, act_low, pend_high, pend_low;
  logic        pend_full;
  logic [3:0]  byte_idx;
  logic [7:0]  csum;
  logic [7:0]  sel_byte;

  logic        accept;     // byte handshake this cycle
  logic        last;       // checksum byte handshake this cycle
  logic        load_in;    // inputs go straight to the active registers
  logic        load_pend;  // pending slot moves to the active registers
  logic        cap_pend;   // inputs go to the pending slot
  logic        drop_evt;   // a full pending slot is being discarded

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    load_in   = 1'b0;
    load_pend = 1'b0;
    cap_pend  = 1'b0;
    drop_evt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (meas_finish) begin
          load_in   = 1'b1;
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        accept = tx_ready;
        last   = tx_ready && (byte_idx == IDX_CSUM);
        if (last) begin
          // A result arriving on the final handshake is the freshest one, so
          // it becomes the next frame and any older pending result is lost.
          if (meas_finish) begin
            load_in  = 1'b1;
            drop_evt = pend_full;
          end else if (pend_full) begin
            load_pend = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (meas_finish) begin
          cap_pend = 1'b1;
          drop_evt = pend_full;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Active and pending result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_freq  <= '0;
      act_duty  <= '0;
      act_high  <= '0;
      act_low   <= '0;
      pend_freq <= '0;
      pend_duty <= '0;
      pend_high <= '0;
      pend_low  <= '0;
      pend_full <= 1'b0;
    end else begin
      if (load_in) begin
        act_freq <= 32'(meas_freq);
        act_duty <= meas_duty;
        act_high <= 24'(meas_high);
        act_low  <= 24'(meas_low);
      end else if (load_pend) begin
        act_freq <= pend_freq;
        act_duty <= pend_duty;
        act_high <= pend_high;
        act_low  <= pend_low;
      end

      if (cap_pend) begin
        pend_freq <= 32'(meas_freq);
        pend_duty <= meas_duty;
        pend_high <= 24'(meas_high);
        pend_low  <= 24'(meas_low);
        pend_full <= 1'b1;
      end else if (last) begin
        // Slot is either consumed into the next frame or superseded.
        pend_full <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Byte index, checksum, completion pulse and drop counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx   <= '0;
      csum       <= '0;
      frame_done <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= last;

      if (last) begin
        byte_idx <= '0;
        csum     <= '0;
      end else if (accept) begin
        byte_idx <= byte_idx + 4'd1;
        // Header is excluded; index 12 never reaches here (that is 'last').
        if (byte_idx != IDX_HDR) csum <= csum + sel_byte;
      end

      if (drop_evt && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  meas_frame_byte_sel #(
    .HEADER   (HEADER)
  ) u_byte_sel (
    .byte_idx (byte_idx),
    .freq     (act_freq),
    .duty     (act_duty),
    .high     (act_high),
    .low      (act_low),
    .csum     (csum),
    .byte_out (sel_byte)
  );

  assign tx_valid = (state == ST_SEND);
  assign tx_busy  = (state == ST_SEND);
  assign tx_data  = tx_valid ? sel_byte : 8'h00;

endmodule : meas_result_frame_tx
`default_nettype wire

// File: tb/tb_meas_result_frame_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_meas_result_frame_tx
// Description : Self-checking bench for meas_result_frame_tx. Expected frame
//               bytes are queued when results are driven and compared by a
//               monitor as the DUT hands them over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_result_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        meas_finish;
  logic [25:0] meas_freq;
  logic [7:0]  meas_duty;
  logic [19:0] meas_high;
  logic [19:0] meas_low;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_busy;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  meas_result_frame_tx #(
    .HEADER      (8'hA5),
    .FREQ_W      (26),
    .TIME_W      (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .meas_finish (meas_finish),
    .meas_freq   (meas_freq),
    .meas_duty   (meas_duty),
    .meas_high   (meas_high),
    .meas_low    (meas_low),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .frame_done  (frame_done),
    .drop_cnt    (drop_cnt)
  );

  int         checks      = 0;
  int         failures    = 0;
  logic [7:0] exp_q[$];
  int         mon_idx     = 0;
  int         frames_done = 0;
  bit         done_pending = 1'b0;
  bit         prev_stall  = 1'b0;
  logic [7:0] prev_data   = 8'h00;
  logic [7:0] mon_b;

  typedef struct {
    logic [25:0]  freq;
    logic [7:0]   duty;
    logic [19:0]  high;
    logic [19:0]  low;
    logic [103:0] bytes;   // byte 0 in the top 8 bits
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference frame: header, zero-extended fields, sum of bytes 1..11.
  function automatic logic [103:0] make_frame(input logic [25:0] f, input logic [7:0] d,
                                              input logic [19:0] h, input logic [19:0] l);
    logic [87:0] body;
    logic [7:0]  s;
    body = {6'b0, f, d, 4'b0, h, 4'b0, l};
    s = 8'h00;
    for (int k = 0; k < 11; k++) s = s + body[87-8*k -: 8];
    return {8'hA5, body, s};
  endfunction

  task automatic push_frame(input logic [103:0] v);
    for (int k = 0; k < 13; k++) exp_q.push_back(v[103-8*k -: 8]);
  endtask

  task automatic drive_finish(input logic [25:0] f, input logic [7:0] d,
                              input logic [19:0] h, input logic [19:0] l);
    @(posedge clk); #1;
    meas_finish = 1'b1;
    meas_freq   = f;
    meas_duty   = d;
    meas_high   = h;
    meas_low    = l;
    @(posedge clk); #1;
    meas_finish = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_done < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("frame_timeout", 32'(frames_done >= target), 32'd1);
  endtask

  // Byte monitor: compares handshaken bytes, stall stability, tx_valid
  // continuity and the frame_done pulse timing.
  always @(negedge clk) begin
    if (rst_n) begin
      check("frame_done", 32'(frame_done), 32'(done_pending));
      if (frame_done) frames_done++;
      if (frame_done && exp_q.size() > 0) check("no_gap_valid", 32'(tx_valid), 32'd1);
      done_pending = 1'b0;
      if (mon_idx > 0) check("valid_mid_frame", 32'(tx_valid), 32'd1);
      if (prev_stall) check("stall_stable", 32'(tx_data), 32'(prev_data));
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%h required=none", tx_data);
        end else begin
          mon_b = exp_q.pop_front();
          check("byte", 32'(tx_data), 32'(mon_b));
        end
        mon_idx++;
        if (mon_idx == 13) begin
          mon_idx = 0;
          done_pending = 1'b1;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      mon_idx      = 0;
      done_pending = 1'b0;
      prev_stall   = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    int          base;
    int          n;

    rst_n       = 1'b0;
    meas_finish = 1'b0;
    meas_freq   = '0;
    meas_duty   = '0;
    meas_high   = '0;
    meas_low    = '0;
    tx_ready    = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data",    32'(tx_data),    32'd0);
    check("rst_tx_valid",   32'(tx_valid),   32'd0);
    check("rst_tx_busy",    32'(tx_busy),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_tx_valid", 32'(tx_valid), 32'd0);

    // ---------------- table-driven frames, tx_ready held high ----------------
    vecs[0] = '{26'd1000, 8'd50, 20'd25000, 20'd25000,
                104'hA5_000003E8_32_0061A8_0061A8_2F};
    vecs[1] = '{26'h3FFFFFF, 8'd100, 20'hFFFFF, 20'hFFFFF,
                104'hA5_03FFFFFF_64_0FFFFF_0FFFFF_7E};
    for (int i = 2; i < 4; i++) begin
      r = $urandom; vecs[i].freq = r[25:0];
      r = $urandom; vecs[i].duty = r[7:0];
      r = $urandom; vecs[i].high = r[19:0];
      r = $urandom; vecs[i].low  = r[19:0];
      vecs[i].bytes = make_frame(vecs[i].freq, vecs[i].duty, vecs[i].high, vecs[i].low);
    end

    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      base = frames_done;
      push_frame(vecs[i].bytes);
      drive_finish(vecs[i].freq, vecs[i].duty, vecs[i].high, vecs[i].low);
      check("latency_valid", 32'(tx_valid), 32'd1);
      check("latency_busy",  32'(tx_busy),  32'd1);
      check("latency_hdr",   32'(tx_data),  32'hA5);
      wait_frames(base + 1);
      @(posedge clk); #1;
      check("end_busy",  32'(tx_busy),  32'd0);
      check("end_valid", 32'(tx_valid), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // ---------------- random backpressure ----------------
    tx_ready = 1'b0;
    base = frames_done;
    push_frame(vecs[0].bytes);
    drive_finish(vecs[0].freq, vecs[0].duty, vecs[0].high, vecs[0].low);
    n = 0;
    while (frames_done < base + 1 && n < 3000) begin
      @(posedge clk); #1;
      tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("rand_frame_timeout", 32'(frames_done >= base + 1), 32'd1);
    tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- two results during one stalled frame ----------------
    base = frames_done;
    push_frame(make_frame(26'd111, 8'd11, 20'd1111, 20'd2222));
    drive_finish(26'd111, 8'd11, 20'd1111, 20'd2222);
    drive_finish(26'd222, 8'd22, 20'd3333, 20'd4444);
    drive_finish(26'd333, 8'd33, 20'd5555, 20'd6666);
    push_frame(make_frame(26'd333, 8'd33, 20'd5555, 20'd6666));
    repeat (50) @(posedge clk);
    #1;
    check("stall_drop_cnt", 32'(drop_cnt), 32'd1);
    tx_ready = 1'b1;
    wait_frames(base + 2);
    check("two_queue_empty", 32'(exp_q.size()), 32'd0);
    check("two_drop_cnt", 32'(drop_cnt), 32'd1);

    // ---------------- result coincident with checksum handshake ----------------
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    base = frames_done;
    push_frame(make_frame(26'h1234567, 8'h44, 20'h12345, 20'h6789A));
    drive_finish(26'h1234567, 8'h44, 20'h12345, 20'h6789A);
    drive_finish(26'h0ABCDEF, 8'h55, 20'h54321, 20'hA9876);
    push_frame(make_frame(26'h2222222, 8'h66, 20'h77777, 20'h88888));
    @(posedge clk); #1;
    tx_ready = 1'b1;
    repeat (11) @(posedge clk);
    drive_finish(26'h2222222, 8'h66, 20'h77777, 20'h88888);
    wait_frames(base + 2);
    check("coinc_queue_empty", 32'(exp_q.size()), 32'd0);
    check("coinc_drop_cnt", 32'(drop_cnt), 32'd2);

    // ---------------- drop counter saturation ----------------
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    base = frames_done;
    push_frame(make_frame(26'd7, 8'd7, 20'd7, 20'd7));
    drive_finish(26'd7, 8'd7, 20'd7, 20'd7);
    for (int i = 0; i < 300; i++) drive_finish(26'(i), 8'(i), 20'(i), 20'(i));
    push_frame(make_frame(26'd299, 8'(299), 20'd299, 20'd299));
    check("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    tx_ready = 1'b1;
    wait_frames(base + 2);
    check("sat_queue_empty", 32'(exp_q.size()), 32'd0);
    check("sat_drop_hold", 32'(drop_cnt), 32'd255);

    // ---------------- async reset mid-frame ----------------
    repeat (3) @(posedge clk);
    push_frame(vecs[1].bytes);
    drive_finish(vecs[1].freq, vecs[1].duty, vecs[1].high, vecs[1].low);
    n = 0;
    while (mon_idx < 6 && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst_at_byte6_idx", 32'(mon_idx), 32'd6);
    check("byte6_before_rst", 32'(tx_data), 32'h0F);
    rst_n = 1'b0;
    #1;
    check("arst_tx_valid",   32'(tx_valid),   32'd0);
    check("arst_tx_data",    32'(tx_data),    32'd0);
    check("arst_tx_busy",    32'(tx_busy),    32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    check("arst_drop_cnt",   32'(drop_cnt),   32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(tx_valid), 32'd0);
    base = frames_done;
    push_frame(vecs[0].bytes);
    drive_finish(vecs[0].freq, vecs[0].duty, vecs[0].high, vecs[0].low);
    check("post_rst_hdr", 32'(tx_data), 32'hA5);
    wait_frames(base + 1);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_meas_result_frame_tx
`default_nettype wire
